instr_fetch_mem: RTL and testbench

Parametrised, loadable instruction memory with a registered, multi-cycle fetch handshake for the ARM-subset pipeline.
- Replaces the fixed 49-word combinational ROM in the IF stage.
- Sequential loader port fills the array at boot; no hard-coded program.
- Programmable wait-state counter models slow instruction storage; the IF stage stalls on `fetch_ready`.
- Misaligned or out-of-range fetches return a NOP and raise a fault flag.

---
 rtl/instr_fetch_mem.sv | 138 +++++++++++++
 tb/tb_instr_fetch_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a registered, multi-cycle fetch handshake.
// A sequential loader fills the array; fetches take WAIT_CYCLES extra cycles.
module instr_fetch_mem #(
  parameter int unsigned       DEPTH       = 64,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] NOP_WORD    = 32'hE000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_req,
  input  logic [ADDR_W-1:0]            fetch_addr,
  input  logic                         flush,
  output logic                         fetch_ready,
  output logic [DATA_W-1:0]            inst,
  output logic                         inst_fault,
  output logic                         busy,
  input  logic                         load_en,
  input  logic [DATA_W-1:0]            load_data,
  input  logic                         load_clr,
  output logic [$clog2(DEPTH+1)-1:0]   load_count,
  output logic                         load_full
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [3:0]  WINIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_wcnt;
  logic [AW-1:0]       r_idx;
  logic                r_pfault;
  logic [DATA_W-1:0]   r_inst;
  logic                r_fault;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_capture;
  logic [AW-1:0]       w_cap_idx;
  logic                w_cap_fault;
  logic [ADDR_W-3:0]   w_word;
  logic                w_fault_in;
  logic                w_busy;
  logic                w_full;
  logic                w_ld_we;

  assign w_word     = fetch_addr[ADDR_W-1:2];
  assign w_fault_in = (|fetch_addr[1:0]) || (w_word >= (ADDR_W-2)'(DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_RESP)) &&
                      fetch_req && !flush && !load_en;
  assign w_ld_we    = load_en && !w_busy && !w_full && !load_clr;

  // With zero wait states the response is captured on the accept edge itself,
  // straight from the incoming address; otherwise from the latched one.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_cap_idx   = r_idx;
    w_cap_fault = r_pfault;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
            w_capture   = 1'b1;
            w_cap_idx   = w_word[AW-1:0];
            w_cap_fault = w_fault_in;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_wcnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_capture   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt   <= '0;
      r_idx    <= '0;
      r_pfault <= 1'b0;
      r_inst   <= NOP_WORD;
      r_fault  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wcnt   <= WINIT;
        r_idx    <= w_word[AW-1:0];
        r_pfault <= w_fault_in;
      end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
      if (w_capture) begin
        r_inst  <= w_cap_fault ? NOP_WORD : r_mem[w_cap_idx];
        r_fault <= w_cap_fault;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (load_clr) r_cnt <= '0;
    else if (w_ld_we)  r_cnt <= r_cnt + CW'(1);
  end

  // Array has no reset so program contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_ld_we) r_mem[r_cnt[AW-1:0]] <= load_data;
  end

  assign fetch_ready = (r_state == S_RESP);
  assign inst        = r_inst;
  assign inst_fault  = r_fault;
  assign busy        = w_busy;
  assign load_count  = r_cnt;
  assign load_full   = w_full;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: three instances (0/3/2 wait states) checked every
// cycle against an edge-count based transaction model.
module tb_instr_fetch_mem;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'hE000_0000;
  localparam int          NI    = 3;
  localparam int          WCS [NI] = '{0, 3, 2};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req [NI], flush [NI], lden [NI], lclr [NI];
  logic [31:0] addr [NI], ldata [NI];
  logic rdy [NI], busy [NI], flt [NI], full [NI];
  logic [31:0] inst [NI];
  logic [CW-1:0] lcnt [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    instr_fetch_mem #(
      .DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32),
      .WAIT_CYCLES(WCS[g]), .NOP_WORD(NOP)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(req[g]), .fetch_addr(addr[g]), .flush(flush[g]),
      .fetch_ready(rdy[g]), .inst(inst[g]), .inst_fault(flt[g]), .busy(busy[g]),
      .load_en(lden[g]), .load_data(ldata[g]), .load_clr(lclr[g]),
      .load_count(lcnt[g]), .load_full(full[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: a fetch accepted at edge a responds after edge a+W.
  logic [31:0] m_mem [NI][DEPTH];
  int          m_cnt [NI];
  bit          m_pend [NI];
  int          m_due [NI];
  logic [31:0] m_rinst [NI], m_hinst [NI];
  bit          m_rflt [NI], m_hflt [NI];
  int          cyc = 0;

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_cnt[k] = 0; m_pend[k] = 1'b0; m_due[k] = 0;
      m_hinst[k] = NOP; m_hflt[k] = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        for (int k = 0; k < NI; k++) begin
          bit in_wait, was_busy, acc;
          int word;
          in_wait  = m_pend[k] && (cyc <= m_due[k]);
          was_busy = m_pend[k] && (cyc - 1 <= m_due[k]);
          if (lclr[k]) m_cnt[k] = 0;
          else if (lden[k] && !was_busy && m_cnt[k] < DEPTH) begin
            m_mem[k][m_cnt[k]] = ldata[k];
            m_cnt[k]++;
          end
          acc = !in_wait && req[k] && !flush[k] && !lden[k];
          if (in_wait && flush[k]) m_pend[k] = 1'b0;
          if (acc) begin
            m_pend[k] = 1'b1;
            m_due[k]  = cyc + WCS[k];
            word      = int'(addr[k] >> 2);
            if (addr[k][1:0] != 2'b00 || (addr[k] >> 2) >= DEPTH) begin
              m_rinst[k] = NOP; m_rflt[k] = 1'b1;
            end else begin
              m_rinst[k] = m_mem[k][word]; m_rflt[k] = 1'b0;
            end
          end
          if (m_pend[k] && cyc == m_due[k]) begin
            m_hinst[k] = m_rinst[k]; m_hflt[k] = m_rflt[k];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        bit er, eb;
        er = m_pend[k] && (cyc == m_due[k]);
        eb = m_pend[k] && (cyc <= m_due[k]);
        chk($sformatf("k%0d_ready", k), 32'(rdy[k]), 32'(er));
        chk($sformatf("k%0d_busy", k), 32'(busy[k]), 32'(eb));
        chk($sformatf("k%0d_inst", k), inst[k], m_hinst[k]);
        chk($sformatf("k%0d_fault", k), 32'(flt[k]), 32'(m_hflt[k]));
        chk($sformatf("k%0d_lcount", k), 32'(lcnt[k]), 32'(m_cnt[k]));
        chk($sformatf("k%0d_lfull", k), 32'(full[k]), 32'(m_cnt[k] == DEPTH));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NI; k++) begin
      req[k] = 1'b0; flush[k] = 1'b0; lden[k] = 1'b0; lclr[k] = 1'b0;
      addr[k] = '0; ldata[k] = '0;
    end
  endtask

  task automatic fetch1(input int k, input logic [31:0] a);
    req[k] = 1'b1; addr[k] = a;
    step();
    req[k] = 1'b0;
  endtask

  logic [31:0] prog [4] = '{32'hE3A0_0014, 32'hE3A0_1A01, 32'hE3A0_2103, 32'hE092_3002};

  initial begin
    clear_all();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step();

    // Fill every array, then two extra pulses that must be dropped.
    for (int i = 0; i < DEPTH + 2; i++) begin
      for (int k = 0; k < NI; k++) begin
        lden[k]  = 1'b1;
        ldata[k] = (i < 4) ? prog[i] : $urandom;
      end
      step();
    end
    clear_all();
    step();
    chk("full_after_sat", 32'(full[0]), 32'd1);
    chk("count_after_sat", 32'(lcnt[0]), DEPTH);

    // Back-to-back fetches with zero wait states.
    req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[0] = 32'(i * 4);
      step();
    end
    req[0] = 1'b0;
    step(2);

    // Wait states: address 4 on the 3-wait instance.
    fetch1(1, 32'd4);
    step(5);

    // Faults: misaligned, out of range, then a clean fetch.
    fetch1(0, 32'd6);
    fetch1(0, 32'(DEPTH * 4));
    fetch1(0, 32'd0);
    step(2);

    // Flush in first WAIT cycle, then flush together with a request.
    fetch1(2, 32'd4);
    flush[2] = 1'b1;
    step();
    flush[2] = 1'b0;
    step(4);
    req[2] = 1'b1; flush[2] = 1'b1; addr[2] = 32'd8;
    step();
    clear_all();
    step(3);

    // Loader: clear, writes ignored while busy, load beats fetch in IDLE.
    lclr[1] = 1'b1; lden[1] = 1'b1; ldata[1] = 32'hDEAD_BEEF;
    step();
    clear_all();
    fetch1(1, 32'd0);
    lden[1] = 1'b1; ldata[1] = 32'h1111_2222;
    step(3);
    lden[1] = 1'b0;
    step(2);
    lden[1] = 1'b1; ldata[1] = 32'hCAFE_0001; req[1] = 1'b1; addr[1] = 32'd0;
    step();
    lden[1] = 1'b0;
    step();
    req[1] = 1'b0;
    step(5);

    // Asynchronous reset in the middle of WAIT.
    fetch1(1, 32'd8);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy[1]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_inst", inst[1], NOP);
    chk("rst_fault", 32'(flt[1]), 32'd0);
    chk("rst_lcount", 32'(lcnt[1]), 32'd0);
    step();
    rst_n = 1'b1;
    step(2);
    fetch1(1, 32'd8);
    step(5);
    fetch1(1, 32'd12);
    step(5);

    // Randomised traffic on all instances.
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NI; k++) begin
        req[k]   = ($urandom % 4) != 0;
        addr[k]  = (($urandom % 8) == 0) ? 32'($urandom_range(0, DEPTH * 4 + 16))
                                          : 32'($urandom_range(0, DEPTH - 1)) << 2;
        flush[k] = ($urandom % 10) == 0;
        lden[k]  = ($urandom % 12) == 0;
        ldata[k] = $urandom;
        lclr[k]  = ($urandom % 40) == 0;
      end
      step();
    end
    clear_all();
    step(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
